// File: rtl/baud_nco_pkg.sv
`default_nettype none
// =====================================================================
// baud_nco_pkg - shared constants, types and helpers for baud_nco
// Rev 1.0
// =====================================================================
package baud_nco_pkg;

  localparam int ACC_W_DEF = 26;
  localparam int INC_DEF   = 154619;

  typedef logic [ACC_W_DEF-1:0] acc_word_t;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_nco_rstgen.sv
`default_nettype none
// =====================================================================
// baud_nco_rstgen - holds rst_out until RST_TICKS clock-enable ticks
// Rev 1.0
// =====================================================================
module baud_nco_rstgen
  import baud_nco_pkg::*;
#(
  parameter int RST_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic rst_out
);

  localparam int                CNT_W = clog2(RST_TICKS + 1);
  localparam logic [CNT_W-1:0] C_SAT = CNT_W'(RST_TICKS);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rst_out;

  assign w_cnt_nxt = (tick && (r_cnt != C_SAT)) ? r_cnt + 1'b1 : r_cnt;

  // Decode the next count so rst_out drops right after the last tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rst_out <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_rst_out <= (w_cnt_nxt < C_SAT);
    end
  end

  assign rst_out = r_rst_out;

endmodule
`default_nettype wire

// File: rtl/baud_nco.sv
`default_nettype none
// =====================================================================
// baud_nco - phase-accumulator baud tick generator with reset stretcher
// Optional divide-by-16 / resync feature: BAUD_NCO_DIV16_EN.  Rev 1.0
// =====================================================================
module baud_nco
  import baud_nco_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int INC_RST   = INC_DEF,
  parameter int RST_TICKS = 3
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             en,
  input  logic             inc_wr,
  input  logic [ACC_W-1:0] inc_din,
  input  logic             resync,
  output logic             tick,
  output logic             clk_out,
  output logic             tick_div16,
  output logic             rst_out,
  output logic [ACC_W-1:0] inc_q
);

  localparam logic [ACC_W-1:0] C_INC_RST = ACC_W'(INC_RST);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc_act;
  logic [ACC_W-1:0] r_inc_shadow;
  logic             r_pending;
  logic             r_tick;
  logic [ACC_W:0]   w_sum;
  logic             w_resync;
  logic             w_apply;

`ifdef BAUD_NCO_DIV16_EN
  assign w_resync = resync;
`else
  logic w_unused_resync;
  assign w_unused_resync = resync;
  assign w_resync        = 1'b0;
`endif

  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc_act};

  // A fresh write always waits for a later carry, even if one occurs now.
  assign w_apply = r_pending && !inc_wr && !w_resync && (en ? w_sum[ACC_W] : 1'b1);

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_acc        <= '0;
      r_inc_act    <= C_INC_RST;
      r_inc_shadow <= C_INC_RST;
      r_pending    <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      if (inc_wr) begin
        r_inc_shadow <= inc_din;
        r_pending    <= 1'b1;
      end else if (w_apply) begin
        r_inc_act <= r_inc_shadow;
        r_pending <= 1'b0;
      end

      if (w_resync) begin
        r_acc  <= '0;
        r_tick <= 1'b0;
      end else if (en) begin
        r_acc  <= w_sum[ACC_W-1:0];
        r_tick <= w_sum[ACC_W];
      end else begin
        r_tick <= 1'b0;
      end
    end
  end

`ifdef BAUD_NCO_DIV16_EN
  logic [3:0] r_sub;
  logic       r_div16;

  // Resync preloads mid-count so the first divided pulse lands mid-bit.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_sub   <= 4'd0;
      r_div16 <= 1'b0;
    end else if (w_resync) begin
      r_sub   <= 4'd8;
      r_div16 <= 1'b0;
    end else if (r_tick) begin
      r_sub   <= r_sub + 4'd1;
      r_div16 <= (r_sub == 4'd15);
    end else begin
      r_div16 <= 1'b0;
    end
  end

  assign tick_div16 = r_div16;
`else
  assign tick_div16 = 1'b0;
`endif

  baud_nco_rstgen #(
    .RST_TICKS (RST_TICKS)
  ) u_rstgen (
    .clk     (clk_100M),
    .rst     (rst),
    .tick    (r_tick),
    .rst_out (rst_out)
  );

  assign tick    = r_tick;
  assign clk_out = r_acc[ACC_W-1];
  assign inc_q   = r_inc_act;

endmodule
`default_nettype wire

// File: tb/tb_baud_nco.sv
`default_nettype none
// =====================================================================
// tb_baud_nco - directed self-checking bench, ACC_W=4 INC_RST=4 RST_TICKS=3
// Rev 1.0
// =====================================================================
module tb_baud_nco;

  logic       clk_100M = 1'b0;
  logic       rst      = 1'b1;
  logic       en       = 1'b1;
  logic       inc_wr   = 1'b0;
  logic [3:0] inc_din  = 4'd0;
  logic       resync   = 1'b0;
  logic       tick;
  logic       clk_out;
  logic       tick_div16;
  logic       rst_out;
  logic [3:0] inc_q;

  int n_total = 0;
  int n_bad   = 0;

  baud_nco #(
    .ACC_W     (4),
    .INC_RST   (4),
    .RST_TICKS (3)
  ) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .en         (en),
    .inc_wr     (inc_wr),
    .inc_din    (inc_din),
    .resync     (resync),
    .tick       (tick),
    .clk_out    (clk_out),
    .tick_div16 (tick_div16),
    .rst_out    (rst_out),
    .inc_q      (inc_q)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic step();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    int nt;
    logic prev;

    // Reset state
    step(); step();
    chk("rst_tick",    0, 32'(tick), 32'd0);
    chk("rst_clkout",  0, 32'(clk_out), 32'd0);
    chk("rst_div16",   0, 32'(tick_div16), 32'd0);
    chk("rst_rstout",  0, 32'(rst_out), 32'd1);
    chk("rst_incq",    0, 32'(inc_q), 32'd4);

    // Basic tick cadence, clk_out shape, rst_out release
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("p1_tick",   c, 32'(tick), 32'((c % 4) == 0));
      chk("p1_clkout", c, 32'(clk_out), 32'((c % 4) >= 2));
      chk("p1_rstout", c, 32'(rst_out), 32'(c <= 12));
      chk("p1_div16",  c, 32'(tick_div16), 32'd0);
    end
    rst = 1'b1;
    step();
    chk("p2_rstout_reassert", 0, 32'(rst_out), 32'd1);
    chk("p2_tick_reassert",   0, 32'(tick), 32'd0);

    // Increment write mid-period: applies at next carry, then 3,3,2 spacing
    rst = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      inc_wr  = (c == 5);
      inc_din = 4'd6;
      step();
      chk("p3_tick", c, 32'(tick), 32'(c inside {4, 8, 11, 14, 16, 19, 22, 24}));
      chk("p3_incq", c, 32'(inc_q), (c < 8) ? 32'd4 : 32'd6);
    end
    inc_wr = 1'b0;
    rst = 1'b1;
    step();
    chk("p3_incq_reset", 0, 32'(inc_q), 32'd4);

    // Enable gap freezes phase; stretcher only advances on ticks
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      en = !(c >= 9 && c <= 13);
      step();
      chk("p4_tick",   c, 32'(tick), 32'(c inside {4, 8, 17}));
      chk("p4_rstout", c, 32'(rst_out), 32'(c <= 17));
      if (c >= 9 && c <= 13) chk("p4_frozen", c, 32'(clk_out), 32'd0);
    end
    en  = 1'b1;
    rst = 1'b1;
    step();

    // Write coinciding with a carry waits for the following carry
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      inc_wr  = (c == 8);
      inc_din = 4'd6;
      step();
      chk("p5_tick", c, 32'(tick), 32'(c inside {4, 8, 12, 15}));
      chk("p5_incq", c, 32'(inc_q), (c < 12) ? 32'd4 : 32'd6);
    end
    inc_wr = 1'b0;
    rst = 1'b1;
    step();

    // Reset mid-operation discards a pending increment
    rst = 1'b0;
    step();
    inc_wr = 1'b1;
    inc_din = 4'd6;
    step();
    inc_wr = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("p6_tick", c, 32'(tick), 32'(c inside {4, 8}));
      chk("p6_incq", c, 32'(inc_q), 32'd4);
    end
    rst = 1'b1;
    step();

    // Zero increment written while disabled: applies next edge, no ticks
    rst = 1'b0;
    en = 1'b0;
    inc_wr = 1'b1;
    inc_din = 4'd0;
    step();
    inc_wr = 1'b0;
    step();
    chk("p7_incq_zero", 2, 32'(inc_q), 32'd0);
    en = 1'b1;
    for (int c = 3; c <= 22; c++) begin
      step();
      chk("p7_tick",   c, 32'(tick), 32'd0);
      chk("p7_rstout", c, 32'(rst_out), 32'd1);
    end
    rst = 1'b1;
    step();

`ifdef BAUD_NCO_DIV16_EN
    // Resync: suppressed tick, first div16 after 8 ticks then every 16
    rst = 1'b0;
    en = 1'b0;
    inc_wr = 1'b1;
    inc_din = 4'd8;
    step();
    inc_wr = 1'b0;
    step();
    chk("p8_incq", 0, 32'(inc_q), 32'd8);
    en = 1'b1;
    step(); step(); step();
    resync = 1'b1;
    step();
    chk("p8_resync_tick", 0, 32'(tick), 32'd0);
    resync = 1'b0;
    nt = 0;
    prev = 1'b0;
    for (int c = 1; c <= 52; c++) begin
      step();
      chk("p8_div16", c, 32'(tick_div16), 32'(prev && (nt == 8 || nt == 24)));
      if (tick) nt++;
      prev = tick;
    end
    rst = 1'b1;
    step();
    chk("p8_div16_rst", 0, 32'(tick_div16), 32'd0);
    rst = 1'b0;
    nt = 0;
    prev = 1'b0;
    for (int c = 1; c <= 72; c++) begin
      step();
      chk("p9_div16", c, 32'(tick_div16), 32'(prev && nt == 16));
      if (tick) nt++;
      prev = tick;
    end
`else
    // Without the feature resync has no effect
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      resync = (c == 4);
      step();
      chk("p8_tick_noresync", c, 32'(tick), 32'(c inside {4, 8}));
      chk("p8_div16_off",     c, 32'(tick_div16), 32'd0);
    end
    resync = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
